// File: rtl/decode_cycle.sv
// RV32I decode stage: control/ALU decode, 32x32 register file, immediate extension, ID/EX register.
// Optional DECODE_WB_BYPASS_EN forwards a same-cycle writeback onto the register read ports.
module decode_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RDW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic        ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1_E,
    output logic [31:0] RD2_E,
    output logic [31:0] Imm_Ext_E,
    output logic [4:0]  RD_E,
    output logic [4:0]  RS1_E,
    output logic [4:0]  RS2_E,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E
);

    typedef enum logic [1:0] {ImmI = 2'b00, ImmS = 2'b01, ImmB = 2'b10} imm_src_e;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2;
    logic        is_rtype;
    logic        reg_write, mem_write, branch, alu_src, result_src;
    logic [1:0]  alu_op;
    imm_src_e    imm_src;
    logic [2:0]  alu_ctrl;
    logic [31:0] imm_ext;
    logic [31:0] rd1, rd2;
    logic        wb_en;

    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    // Packed E-stage register: {ctrl[4:0], alu[2:0], rd1, rd2, imm, rd, rs1, rs2, pc, pc4}
    localparam int unsigned EW = 5 + 3 + 32 * 3 + 5 * 3 + 32 * 2;
    logic [EW-1:0] e_q, e_d;

    assign opcode   = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign rs1      = InstrD[19:15];
    assign rs2      = InstrD[24:20];
    assign is_rtype = (opcode == 7'b0110011);
    assign wb_en    = RegWriteW && (RDW != 5'd0);

    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        result_src = 1'b0;
        alu_op     = 2'b00;
        imm_src    = ImmI;
        unique case (opcode)
            7'b0000011: begin reg_write = 1'b1; alu_src = 1'b1; result_src = 1'b1; end
            7'b0100011: begin mem_write = 1'b1; alu_src = 1'b1; imm_src = ImmS; end
            7'b0110011: begin reg_write = 1'b1; alu_op = 2'b10; end
            7'b0010011: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b10; end
            7'b1100011: begin branch = 1'b1; imm_src = ImmB; alu_op = 2'b01; end
            default: ;
        endcase
    end

    always_comb begin
        alu_ctrl = 3'b000;
        case (alu_op)
            2'b01: alu_ctrl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_ctrl = (is_rtype && InstrD[30]) ? 3'b001 : 3'b000;
                    3'b010:  alu_ctrl = 3'b101;
                    3'b110:  alu_ctrl = 3'b011;
                    3'b111:  alu_ctrl = 3'b010;
                    default: alu_ctrl = 3'b000;
                endcase
            end
            default: alu_ctrl = 3'b000;
        endcase
    end

    always_comb begin
        imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
        case (imm_src)
            ImmS:    imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            ImmB:    imm_ext = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                                InstrD[11:8], 1'b0};
            default: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
        endcase
    end

    always_comb begin
        rd1 = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
        rd2 = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && (RDW == rs1)) rd1 = ResultW;
        if (wb_en && (RDW == rs2)) rd2 = ResultW;
`endif
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_en) rf_d[RDW] = ResultW;
    end

    // Flush bubbles only the control fields; data, indices and PCs still load.
    always_comb begin
        e_d = {reg_write, mem_write, branch, alu_src, result_src, alu_ctrl, rd1, rd2, imm_ext,
               InstrD[11:7], rs1, rs2, PCD, PCPlus4D};
        if (FlushE) e_d[EW-1 -: 8] = 8'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            e_q  <= '0;
            rf_q <= '{default: 32'd0};
        end else begin
            e_q  <= e_d;
            rf_q <= rf_d;
        end
    end

    assign {RegWriteE, MemWriteE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, RD1_E, RD2_E,
            Imm_Ext_E, RD_E, RS1_E, RS2_E, PCE, PCPlus4E} = e_q;

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Second stage of the five-stage RV32I pipeline, directly downstream of `fetch_cycle`. It consumes `InstrD`, `PCD` and `PCPlus4D` from the IF/ID register and decodes the instruction into control signals. It reads the 32×32 register file, which is written by the writeback stage, and sign-extends the immediate. All results are registered into the ID/EX pipeline register that feeds the execute stage.

## Interface
- None; widths fixed (XLEN 32, 32 registers).

Ports (clock and reset first):
- `clk` in 1: single clock; everything updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `InstrD` in 32: instruction from the fetch stage.
- `PCD` in 32: PC of `InstrD`.
- `PCPlus4D` in 32: `PCD` + 4.
- `RegWriteW` in 1: writeback write enable.
- `RDW` in 5: writeback destination register.
- `ResultW` in 32: writeback data.
- `FlushE` in 1: turns the instruction entering EX into a bubble.
- `RegWriteE`, `MemWriteE`, `BranchE`, `ALUSrcE`, `ResultSrcE` out 1 each: registered control signals.
- `ALUControlE` out 3: ALU operation code.
- `RD1_E`, `RD2_E` out 32: register operands.
- `Imm_Ext_E` out 32: sign-extended immediate.
- `RD_E`, `RS1_E`, `RS2_E` out 5: register indices.
- `PCE`, `PCPlus4E` out 32: PC values passed through to EX.

## Operation
Control decode on `InstrD[6:0]`:
- lw `0000011`:
  - RegWrite=1, ALUSrc=1, ResultSrc=1.
  - ImmSrc=I, ALUOp=00.
- sw `0100011`:
  - MemWrite=1, ALUSrc=1.
  - ImmSrc=S, ALUOp=00.
- R-type `0110011`: RegWrite=1, ALUOp=10.
- I-ALU `0010011`:
  - RegWrite=1, ALUSrc=1.
  - ImmSrc=I, ALUOp=10.
- beq `1100011`: Branch=1, ImmSrc=B, ALUOp=01.
- Any other opcode: every control bit is 0 (architectural no-op), with ALUControl=000.

ALU decode (`ALUControlE`):
- ALUOp 00 → 000 (add).
- ALUOp 01 → 001 (sub).
- ALUOp 10, by funct3:
  - 000 → 001 (sub) only if R-type with `InstrD[30]`=1; otherwise 000 (add).
  - 010 → 101 (slt).
  - 110 → 011 (or).
  - 111 → 010 (and).
  - Any other funct3 → 000.

Immediate extension, always sign-extended from `InstrD[31]`:
- I: `InstrD[31:20]`.
- S: {`InstrD[31:25]`, `InstrD[11:7]`}.
- B: {`InstrD[31]`, `InstrD[7]`, `InstrD[30:25]`, `InstrD[11:8]`, 0}.

Register file:
- Two asynchronous read ports, indexed by `InstrD[19:15]` and `InstrD[24:20]`.
- One synchronous write port: on the rising edge, when `RegWriteW`=1 and `RDW`≠0, `ResultW` is written to register `RDW`.
- x0 always reads 0. Writes to x0 are discarded.
- `rst`=0 clears all 32 registers to 0.

Register indices passed to EX:
- `RD_E` ← `InstrD[11:7]`.
- `RS1_E` ← `InstrD[19:15]`.
- `RS2_E` ← `InstrD[24:20]`.

## Timing
- Latency is 1 cycle: the instruction present on `InstrD` before edge N appears on all E outputs after edge N.
- There is no stall and no backpressure; a new instruction is accepted every cycle.
- Reset (`rst`=0 at a rising edge):
  - Every E output becomes 0.
  - The register file is cleared.
  - This holds even mid-stream; after `rst` returns to 1 the first decoded result appears one edge later.
- Flush (`FlushE`=1 at an edge):
  - `RegWriteE`, `MemWriteE`, `BranchE`, `ALUSrcE`, `ResultSrcE` and `ALUControlE` load 0.
  - Data, index and PC outputs load normally.
  - Reset takes priority over flush.
- The writeback write and the decode read can target the same register in the same cycle; the required result depends on `DECODE_WB_BYPASS_EN` (see Configuration).

## Configuration
`DECODE_WB_BYPASS_EN`:
- Defined:
  - If `RegWriteW`=1, `RDW`≠0 and `RDW` matches the read index, that read port returns `ResultW` combinationally.
  - `RD1_E`/`RD2_E` therefore capture the new value at the same edge the register file is written.
- Undefined:
  - The read returns the old register content.
  - `RD1_E`/`RD2_E` capture the stale value.
  - The hazard unit must then cover a distance of 3 instructions.

## Test plan
- Reset:
  - Stimulus: hold `rst`=0 for 2 cycles with `InstrD`=0x00500093.
  - Required: every E output is 0.
  - Then release `rst`: after one edge, `RegWriteE`=1, `ALUSrcE`=1, `Imm_Ext_E`=5, `RD_E`=1, `ALUControlE`=000.
- R-type sub:
  - Stimulus: preload x1=7, x2=3 via the W port, then `InstrD`=0x402081B3.
  - Required: `ALUControlE`=001, `RD1_E`=7, `RD2_E`=3, `RD_E`=3, `ALUSrcE`=0.
- Load and store:
  - `InstrD`=0xFFC12283 → `Imm_Ext_E`=0xFFFFFFFC, `ResultSrcE`=1, `RD_E`=5.
  - `InstrD`=0x00612423 → `MemWriteE`=1, `RegWriteE`=0, `Imm_Ext_E`=8.
- Branch with PC pass-through:
  - Stimulus: `InstrD`=0xFE208CE3, `PCD`=0x10.
  - Required: `BranchE`=1, `ALUControlE`=001, `Imm_Ext_E`=0xFFFFFFF8, `PCE`=0x10, `PCPlus4E`=0x14.
- x0 and flush:
  - Stimulus: a write with `RDW`=0, `ResultW`=0xDEAD, then read x0.
  - Required: x0 reads 0.
  - Stimulus: `FlushE`=1 with `InstrD`=0x00500093.
  - Required: all control outputs 0 while `Imm_Ext_E`=5.
- Same-cycle write and read:
  - Stimulus: `RegWriteW`=1, `RDW`=1, `ResultW`=0x55, with `InstrD` reading x1 in the same cycle.
  - Required: `RD1_E`=0x55 with `DECODE_WB_BYPASS_EN` defined; `RD1_E`= old x1 value without it.
